// File: rtl/decay_envelope_pkg.sv
// Shared types and constants for the decay envelope generator and its helpers.
package decay_envelope_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrain
  } state_e;

  localparam int unsigned EXP_ARG_W = 13;
  localparam logic [EXP_ARG_W-1:0] EXP_ARG_MAX = 13'h1FFF;
  localparam int unsigned ENV_W = 8;
  localparam int unsigned RATE_W = 8;
  localparam int unsigned RATE_SHIFT = 4;
  localparam int unsigned OVR_W = 8;

endpackage

// File: rtl/decay_envelope_if.sv
// Request/response link to the shared e^-x stage; master is the envelope, slave the stage.
interface decay_envelope_if;
  import decay_envelope_pkg::*;

  logic                 exp_in_valid;
  logic [EXP_ARG_W-1:0] exp_in_value;
  logic                 exp_out_valid;
  logic [ENV_W-1:0]     exp_out_value;

  modport master (
    output exp_in_valid,
    output exp_in_value,
    input  exp_out_valid,
    input  exp_out_value
  );

  modport slave (
    input  exp_in_valid,
    input  exp_in_value,
    output exp_out_valid,
    output exp_out_value
  );

endinterface

// File: rtl/decay_envelope_sat_scale.sv
// Combinational x = min((elapsed * rate) >> RATE_SHIFT, EXP_ARG_MAX) with a full-width product.
module sat_scale
  import decay_envelope_pkg::*;
#(
  parameter int unsigned ELAPSED_W = 16
) (
  input  logic [ELAPSED_W-1:0] elapsed_i,
  input  logic [RATE_W-1:0]    rate_i,
  output logic [EXP_ARG_W-1:0] arg_o
);

  localparam int unsigned ProdW = ELAPSED_W + RATE_W;

  logic [ProdW-1:0] prod;
  logic [ProdW-1:0] shifted;

  always_comb begin
    prod    = ProdW'(elapsed_i) * ProdW'(rate_i);
    shifted = prod >> RATE_SHIFT;
    if (shifted > ProdW'(EXP_ARG_MAX)) begin
      arg_o = EXP_ARG_MAX;
    end else begin
      arg_o = shifted[EXP_ARG_W-1:0];
    end
  end

endmodule

// File: rtl/decay_envelope.sv
// Exponential decay envelope: per sample tick, asks an external e^-x stage for e^-(t*rate).
// Define DECAY_ENVELOPE_OVERRUN_EN to build the lost-tick (overrun) counter.
module decay_envelope
  import decay_envelope_pkg::*;
#(
  parameter int unsigned ELAPSED_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 sample_tick,
  input  logic [RATE_W-1:0]    decay_rate,
  decay_envelope_if.master     exp_if,
  output logic                 env_valid,
  output logic [ENV_W-1:0]     env_value,
  output logic                 active,
  output logic [OVR_W-1:0]     overrun_count
);

  state_e                 state_q, state_d;
  logic [ELAPSED_W-1:0]   elapsed_q, elapsed_d;
  logic [ELAPSED_W-1:0]   elapsed_inc;
  logic                   active_q, active_d;
  logic [ENV_W-1:0]       env_value_q, env_value_d;
  logic                   env_valid_q, env_valid_d;
  logic                   overrun_inc;
  logic [ELAPSED_W-1:0]   scale_elapsed;
  logic [EXP_ARG_W-1:0]   scale_arg;

  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + ELAPSED_W'(1);

  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    active_d    = active_q;
    env_value_d = env_value_q;
    env_valid_d = 1'b0;
    overrun_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          elapsed_d = '0;
          active_d  = 1'b1;
          state_d   = StReq;
        end else if (active_q && sample_tick) begin
          elapsed_d = elapsed_inc;
          state_d   = StReq;
        end
      end
      StReq: begin
        state_d = StWait;
        if (trigger) begin
          elapsed_d = '0;
        end else if (sample_tick) begin
          elapsed_d   = elapsed_inc;
          overrun_inc = 1'b1;
        end
      end
      StWait: begin
        if (trigger) begin
          // A result landing with the retrigger is stale already; reissue straight away.
          elapsed_d = '0;
          state_d   = exp_if.exp_out_valid ? StReq : StDrain;
        end else begin
          if (sample_tick) begin
            elapsed_d   = elapsed_inc;
            overrun_inc = 1'b1;
          end
          if (exp_if.exp_out_valid) begin
            env_value_d = exp_if.exp_out_value;
            env_valid_d = 1'b1;
            state_d     = StIdle;
            if (exp_if.exp_out_value == '0) begin
              active_d = 1'b0;
            end
          end
        end
      end
      StDrain: begin
        if (trigger) begin
          elapsed_d = '0;
        end else if (sample_tick) begin
          elapsed_d   = elapsed_inc;
          overrun_inc = 1'b1;
        end
        if (exp_if.exp_out_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      elapsed_q   <= '0;
      active_q    <= 1'b0;
      env_value_q <= '0;
      env_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      active_q    <= active_d;
      env_value_q <= env_value_d;
      env_valid_q <= env_valid_d;
    end
  end

  // A retrigger in the request cycle must send x=0, so bypass the stale elapsed value.
  assign scale_elapsed = trigger ? '0 : elapsed_q;

  sat_scale #(
    .ELAPSED_W (ELAPSED_W)
  ) u_sat_scale (
    .elapsed_i (scale_elapsed),
    .rate_i    (decay_rate),
    .arg_o     (scale_arg)
  );

  assign exp_if.exp_in_valid = (state_q == StReq);
  assign exp_if.exp_in_value = (state_q == StReq) ? scale_arg : '0;

  assign env_valid = env_valid_q;
  assign env_value = env_value_q;
  assign active    = active_q;

`ifdef DECAY_ENVELOPE_OVERRUN_EN
  logic [OVR_W-1:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_inc && !(&overrun_q)) begin
      overrun_d = overrun_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_count = overrun_q;
`else
  logic unused_overrun_inc;
  assign unused_overrun_inc = overrun_inc;
  assign overrun_count      = '0;
`endif

endmodule

// File: tb/tb_decay_envelope.sv
// Scoreboard bench for decay_envelope with a latency-programmable e^-x stub.
module tb_decay_envelope;
  import decay_envelope_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 trigger;
  logic                 sample_tick;
  logic [RATE_W-1:0]    decay_rate;
  logic                 env_valid;
  logic [ENV_W-1:0]     env_value;
  logic                 active;
  logic [OVR_W-1:0]     overrun_count;
  logic [EXP_ARG_W-1:0] sat_arg;

  decay_envelope_if ex_if ();

  decay_envelope #(
    .ELAPSED_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger       (trigger),
    .sample_tick   (sample_tick),
    .decay_rate    (decay_rate),
    .exp_if        (ex_if),
    .env_valid     (env_valid),
    .env_value     (env_value),
    .active        (active),
    .overrun_count (overrun_count)
  );

  // Standalone scaler at the elapsed ceiling, which the envelope cannot reach quickly.
  sat_scale #(
    .ELAPSED_W (16)
  ) u_sat (
    .elapsed_i (16'hFFFF),
    .rate_i    (8'hFF),
    .arg_o     (sat_arg)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] req_q[$];
  logic [31:0] env_q[$];
  int          stub_lat = 0;
  logic [7:0]  stub_val = 8'hFF;
  int          ovr_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_x(input int unsigned e, input int unsigned r);
    longint unsigned p;
    p = (longint'(e) * longint'(r)) >> 4;
    return (p > 64'h1FFF) ? 32'h1FFF : 32'(p);
  endfunction

  // e^-x stub: answers stub_lat cycles after the request with stub_val.
  initial begin
    int cd;
    bit pend;
    pend = 1'b0;
    cd   = 0;
    ex_if.exp_out_valid = 1'b0;
    ex_if.exp_out_value = '0;
    forever begin
      @(negedge clk);
      ex_if.exp_out_valid = 1'b0;
      ex_if.exp_out_value = '0;
      if (pend) begin
        if (cd == 0) begin
          ex_if.exp_out_valid = 1'b1;
          ex_if.exp_out_value = stub_val;
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
      if (ex_if.exp_in_valid) begin
        pend = 1'b1;
        cd   = stub_lat;
      end
    end
  end

  // Output monitor: pops expectations as requests and envelope updates appear.
  initial begin
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (ex_if.exp_in_valid) begin
        if (req_q.size() == 0) check("req_unexpected", req_q.size(), 1);
        else check("req_x", 32'(ex_if.exp_in_value), req_q.pop_front());
      end
      if (prev_valid && !ex_if.exp_in_valid) check("x_zero_idle", 32'(ex_if.exp_in_value), 0);
      prev_valid = ex_if.exp_in_valid;
      if (env_valid) begin
        if (env_q.size() == 0) check("env_unexpected", env_q.size(), 1);
        else check("env_value", 32'(env_value), env_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic trig();
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    ovr_model = 0;
  endtask

  task automatic drained(input string tag);
    check(tag, req_q.size() + env_q.size(), 0);
    req_q.delete();
    env_q.delete();
  endtask

  // Retrigger mid-WAIT: the stale answer (8'hA0) must vanish, the reissued x=0 answers new_val.
  task automatic retrigger(input bit with_tick, input logic [7:0] new_val);
    stub_lat = 20;
    stub_val = 8'hA0;
    req_q.push_back(0);
    trig();
    cyc(4);
    trigger     = 1'b1;
    sample_tick = with_tick;
    req_q.push_back(0);
    env_q.push_back(32'(new_val));
    cyc(1);
    trigger     = 1'b0;
    sample_tick = 1'b0;
    cyc(20);
    stub_val = new_val;
    cyc(25);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    trigger     = 1'b0;
    sample_tick = 1'b0;
    decay_rate  = 8'h10;
    cyc(3);
    check("rst_env_value", 32'(env_value), 0);
    check("rst_env_valid", 32'(env_valid), 0);
    check("rst_active", 32'(active), 0);
    check("rst_overrun", 32'(overrun_count), 0);
    check("rst_exp_valid", 32'(ex_if.exp_in_valid), 0);
    check("rst_exp_value", 32'(ex_if.exp_in_value), 0);
    rst = 1'b0;
    cyc(2);

    // First envelope after trigger: x=0, answer FF.
    stub_lat = 0;
    stub_val = 8'hFF;
    req_q.push_back(0);
    env_q.push_back(32'hFF);
    trig();
    cyc(6);
    check("first_active", 32'(active), 1);
    drained("first_drain");

    // Rate 1.0: x follows elapsed 1..5, varied stage answers.
    for (int i = 1; i <= 5; i++) begin
      stub_val = 8'(8'hF0 - i * 8);
      req_q.push_back(model_x(i, 16));
      env_q.push_back(32'(stub_val));
      tick();
      cyc(6);
    end
    drained("ramp_drain");

    // Trigger inside the request cycle forces x=0, then counting restarts.
    stub_val = 8'h77;
    req_q.push_back(0);
    env_q.push_back(32'h77);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    trigger     = 1'b1;
    cyc(1);
    trigger = 1'b0;
    cyc(6);
    stub_val = 8'h76;
    req_q.push_back(model_x(1, 16));
    env_q.push_back(32'h76);
    tick();
    cyc(6);
    drained("req_retrig_drain");

    // Steep rate: x saturates at 1FFF without wrapping.
    do_reset();
    decay_rate = 8'hFF;
    stub_val   = 8'h40;
    req_q.push_back(0);
    env_q.push_back(32'h40);
    trig();
    cyc(5);
    for (int e = 1; e <= 520; e++) begin
      req_q.push_back(model_x(e, 255));
      env_q.push_back(32'h40);
      tick();
      cyc(4);
    end
    drained("sat_drain");
    check("sat_scale_max", 32'(sat_arg), 32'h1FFF);

    // Slow stage: three ticks lost per request.
    do_reset();
    decay_rate = 8'h10;
    stub_lat   = 40;
    stub_val   = 8'h90;
    req_q.push_back(0);
    env_q.push_back(32'h90);
    trig();
    for (int k = 0; k < 3; k++) begin
      cyc(9);
      tick();
    end
    cyc(15);
`ifdef DECAY_ENVELOPE_OVERRUN_EN
    ovr_model = 3;
`endif
    check("overrun_first", 32'(overrun_count), 32'(ovr_model));
    req_q.push_back(model_x(4, 16));
    env_q.push_back(32'h90);
    tick();
    for (int k = 0; k < 3; k++) begin
      cyc(9);
      tick();
    end
    cyc(20);
`ifdef DECAY_ENVELOPE_OVERRUN_EN
    ovr_model = 6;
`endif
    check("overrun_second", 32'(overrun_count), 32'(ovr_model));
    drained("overrun_drain");

    // Retrigger during WAIT, alone and together with a tick (no overrun counted).
    retrigger(1'b0, 8'h55);
    drained("wait_retrig_drain");
    retrigger(1'b1, 8'hB5);
    drained("trig_tick_drain");
    check("trig_tick_overrun", 32'(overrun_count), 32'(ovr_model));

    // Zero result ends the envelope; later ticks raise no requests.
    stub_lat = 0;
    stub_val = 8'h00;
    req_q.push_back(0);
    env_q.push_back(0);
    trig();
    cyc(6);
    check("zero_active", 32'(active), 0);
    check("zero_env", 32'(env_value), 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      cyc(2);
    end
    drained("zero_drain");

    // Reset while waiting: the late answer after release must be ignored.
    stub_lat = 10;
    stub_val = 8'h33;
    req_q.push_back(0);
    trig();
    cyc(4);
    do_reset();
    check("midrst_active", 32'(active), 0);
    check("midrst_overrun", 32'(overrun_count), 0);
    cyc(20);
    check("midrst_env", 32'(env_value), 0);
    drained("midrst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
